// File: rtl/divisor_secuencial.sv
// 4-bit unsigned sequential divider using restoring division, one quotient bit per clock.
// A zero divisor finishes at once with Q=4'b1111, R=OP1 and the dz flag set.
module divisor_secuencial (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] OP1,
  input  logic [3:0] OP2,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       dz
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic [3:0] a;
  logic [3:0] qw;
  logic [3:0] m;
  logic [1:0] cnt;
  logic [4:0] shifted;
  logic [4:0] diff;
  logic [3:0] a_next;
  logic [3:0] qw_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (OP2 == 4'd0) ? FIN : CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC:    if (cnt == 2'd3) next_state = FIN;
      default: next_state = IDLE;
    endcase
  end

  // One restoring step. The partial remainder stays below the divisor between
  // steps, so its 5th bit only exists transiently in shifted/diff.
  always_comb begin
    shifted = {1'b0, a, qw[3]};
    shifted = {a, qw[3]};
    diff    = shifted - {1'b0, m};
    if (diff[4]) begin
      a_next  = shifted[3:0];
      qw_next = {qw[2:0], 1'b0};
    end else begin
      a_next  = diff[3:0];
      qw_next = {qw[2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a   <= 4'd0;
      qw  <= 4'd0;
      m   <= 4'd0;
      cnt <= 2'd0;
      Q   <= 4'd0;
      R   <= 4'd0;
      dz  <= 1'b0;
    end else if (accept) begin
      a   <= 4'd0;
      cnt <= 2'd0;
      qw  <= OP1;
      m   <= OP2;
      if (OP2 == 4'd0) begin
        Q  <= 4'b1111;
        R  <= OP1;
        dz <= 1'b1;
      end
    end else if (state == CALC) begin
      a   <= a_next;
      qw  <= qw_next;
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        Q  <= qw_next;
        R  <= a_next;
        dz <= 1'b0;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == FIN);

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: directed scenarios, an exhaustive
// operand sweep and random operations, all against plain-arithmetic division.
module tb_divisor_secuencial;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] op1;
  logic [3:0] op2;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dz;

  int checks   = 0;
  int failures = 0;

  divisor_secuencial dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .OP1  (op1),
    .OP2  (op2),
    .Q    (q),
    .R    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: integer division, with the divide-by-zero convention.
  task automatic refDiv(input int a, input int b, output int eq, output int er, output int edz);
    if (b == 0) begin
      eq = 15; er = a; edz = 1;
    end else begin
      eq = a / b; er = a % b; edz = 0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_q"},    q,    0);
    checkOutput({tag, "_r"},    r,    0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_dz"},   dz,   0);
  endtask

  // One full operation: pulse start, scramble operands after acceptance,
  // then check latency, busy length, results and that done is one cycle wide.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    int eq, er, edz, cycles, busyCount;
    bit seen;
    refDiv(int'(a), int'(b), eq, er, edz);
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op1 = 4'($urandom);
    op2 = 4'($urandom);
    cycles = 0; busyCount = 0; seen = 1'b0;
    while (!seen && cycles < 12) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
      else if (busy) busyCount++;
    end
    if (!seen) begin
      checkOutput($sformatf("timeout_%0d_%0d", a, b), 0, 1);
    end else begin
      checkOutput($sformatf("latency_%0d_%0d", a, b), cycles, (b == 0) ? 1 : 5);
      checkOutput($sformatf("busylen_%0d_%0d", a, b), busyCount, (b == 0) ? 0 : 4);
      checkOutput($sformatf("q_%0d_%0d", a, b), q, eq);
      checkOutput($sformatf("r_%0d_%0d", a, b), r, er);
      checkOutput($sformatf("dz_%0d_%0d", a, b), dz, edz);
      @(negedge clk);
      checkOutput($sformatf("donepulse_%0d_%0d", a, b), done, 0);
      checkOutput($sformatf("hold_q_%0d_%0d", a, b), q, eq);
    end
  endtask

  initial begin
    int eq, er, edz, cycles, doneCount, lastDone;
    bit seen;
    reset = 1'b1; start = 1'b0; op1 = 4'd0; op2 = 4'd0;

    #2 reset = 1'b0;
    #1 checkAllZero("reset_async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("after_release");

    // Directed scenarios
    applyStimulus(4'd13, 4'd3);
    applyStimulus(4'd7,  4'd9);
    applyStimulus(4'd15, 4'd1);
    applyStimulus(4'd0,  4'd5);
    applyStimulus(4'd6,  4'd0);

    // A second start during CALC must be ignored
    @(negedge clk);
    start = 1'b1; op1 = 4'd12; op2 = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; op1 = 4'd9; op2 = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 12) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    checkOutput("ignore_seen_done", seen, 1);
    checkOutput("ignore_q", q, 2);
    checkOutput("ignore_r", r, 2);
    @(negedge clk);
    checkOutput("ignore_no_busy", busy, 0);
    checkOutput("ignore_no_done", done, 0);

    // Reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op1 = 4'd12; op2 = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("midcalc_busy", busy, 1);
    #2 reset = 1'b0;
    #1 checkAllZero("midcalc_reset");
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("midcalc_no_done", seen, 0);
    applyStimulus(4'd14, 4'd4);

    // start held high: back-to-back operations every 5 cycles
    @(negedge clk);
    start = 1'b1; op1 = 4'd10; op2 = 4'd3;
    doneCount = 0; lastDone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        checkOutput("b2b_gap", i - lastDone, 5);
        checkOutput("b2b_q", q, 3);
        checkOutput("b2b_r", r, 1);
        lastDone = i;
      end
    end
    checkOutput("b2b_count", doneCount, 4);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Exhaustive sweep with random idle gaps between operations
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        applyStimulus(4'(a), 4'(b));
      end
    end

    // Random operations
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
